// File: rtl/demux_slot_scheduler_if.sv
// Bus between the serial source/controller and the demux slot scheduler.
interface demux_slot_scheduler_if #(
    parameter int SLOT_W = 4
);
    logic              start;
    logic              stop;
    logic [3:0]        ch_en;
    logic [SLOT_W-1:0] slot_len;
    logic              din;
    logic              din_valid;
    logic [1:0]        sel;
    logic [3:0]        dout;
    logic [3:0]        dout_valid;
    logic              busy;
    logic              slot_start;
    logic              frame_done;

    modport master (
        output start, stop, ch_en, slot_len, din, din_valid,
        input  sel, dout, dout_valid, busy, slot_start, frame_done
    );

    modport slave (
        input  start, stop, ch_en, slot_len, din, din_valid,
        output sel, dout, dout_valid, busy, slot_start, frame_done
    );
endinterface

// File: rtl/demux_slot_scheduler.sv
// Round-robin time-slot scheduler for a 1-to-4 serial demux with registered
// per-channel outputs, slot-start and frame-done markers.
module demux_slot_scheduler #(
    parameter int SLOT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_slot_scheduler_if.slave   bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic [SLOT_W-1:0] len_q, len_d;
    logic              stop_pend_q, stop_pend_d;
    logic              slot_start_q, slot_start_d;
    logic [3:0]        dout_q, dout_d;
    logic [3:0]        dout_valid_q, dout_valid_d;

    logic              slot_last;
    logic              leave;
    logic              wrap;
    logic [1:0]        nxt;

    // Circular search starting just above cur; returns cur when nothing is enabled.
    function automatic logic [1:0] next_ch(input logic [3:0] en, input logic [1:0] cur);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && en[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [SLOT_W-1:0] eff_len(input logic [SLOT_W-1:0] l);
        return (l == '0) ? SLOT_W'(1) : l;
    endfunction

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        stop_pend_d  = stop_pend_q;
        slot_start_d = 1'b0;

        slot_last = (state_q == ACTIVE) && (cnt_q == len_q - SLOT_W'(1));
        nxt       = next_ch(bus.ch_en, sel_q);
        wrap      = (nxt <= sel_q);
        leave     = stop_pend_q || bus.stop || (bus.ch_en == 4'b0000);

        case (state_q)
            IDLE: begin
                // Searching "above 3" wraps to bit 0, giving the lowest enabled channel.
                if (bus.start && !bus.stop && (bus.ch_en != 4'b0000)) begin
                    state_d      = ACTIVE;
                    sel_d        = next_ch(bus.ch_en, 2'd3);
                    cnt_d        = '0;
                    len_d        = eff_len(bus.slot_len);
                    stop_pend_d  = 1'b0;
                    slot_start_d = 1'b1;
                end
            end
            default: begin
                if (bus.stop) stop_pend_d = 1'b1;
                if (slot_last) begin
                    if (leave) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        sel_d        = nxt;
                        cnt_d        = '0;
                        len_d        = eff_len(bus.slot_len);
                        slot_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + SLOT_W'(1);
                end
            end
        endcase

        dout_d       = 4'b0000;
        dout_valid_d = 4'b0000;
        if (state_q == ACTIVE) begin
            dout_d       = (4'b0001 << sel_q) & {4{bus.din & bus.din_valid}};
            dout_valid_d = (4'b0001 << sel_q) & {4{bus.din_valid}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            cnt_q        <= '0;
            len_q        <= SLOT_W'(1);
            stop_pend_q  <= 1'b0;
            slot_start_q <= 1'b0;
            dout_q       <= 4'b0000;
            dout_valid_q <= 4'b0000;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            stop_pend_q  <= stop_pend_d;
            slot_start_q <= slot_start_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q == ACTIVE);
    assign bus.slot_start = slot_start_q;
    assign bus.frame_done = slot_last && (wrap || leave);
endmodule

// File: tb/tb_demux_slot_scheduler.sv
// Directed bench for demux_slot_scheduler: per-cycle comparison against a
// slot-countdown model plus hand-computed expectations for each scenario.
module tb_demux_slot_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    demux_slot_scheduler_if #(.SLOT_W(4)) bus ();
    demux_slot_scheduler #(.SLOT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Model state: whether a schedule runs, which channel owns the slot,
    // how many cycles of the slot remain, and the outputs one cycle behind.
    bit         m_active  = 1'b0;
    bit         m_first   = 1'b0;
    bit         m_stopreq = 1'b0;
    int         m_ch      = 0;
    int         m_left    = 0;
    logic [3:0] m_dout    = 4'b0000;
    logic [3:0] m_dv      = 4'b0000;

    function automatic int eff(input logic [3:0] l);
        return (l == 4'd0) ? 1 : int'(l);
    endfunction

    function automatic int lowest(input logic [3:0] en);
        for (int k = 0; k < 4; k++) if (en[k]) return k;
        return 0;
    endfunction

    function automatic bit has_higher(input logic [3:0] en, input int cur);
        for (int k = cur + 1; k < 4; k++) if (en[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_of(input logic [3:0] en, input int cur);
        for (int k = cur + 1; k < 4; k++) if (en[k]) return k;
        return lowest(en);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_active = 1'b0; m_first = 1'b0; m_stopreq = 1'b0;
            m_ch = 0; m_left = 0; m_dout = 4'b0000; m_dv = 4'b0000;
        end else begin
            m_dout = (m_active && bus.din && bus.din_valid) ? 4'(1 << m_ch) : 4'b0000;
            m_dv   = (m_active && bus.din_valid) ? 4'(1 << m_ch) : 4'b0000;
            if (!m_active) begin
                m_first = 1'b0;
                if (bus.start && !bus.stop && bus.ch_en != 4'b0000) begin
                    m_active = 1'b1; m_first = 1'b1; m_stopreq = 1'b0;
                    m_ch = lowest(bus.ch_en); m_left = eff(bus.slot_len);
                end
            end else if (m_left == 1) begin
                if (m_stopreq || bus.stop || bus.ch_en == 4'b0000) begin
                    m_active = 1'b0; m_first = 1'b0; m_stopreq = 1'b0;
                end else begin
                    m_ch = next_of(bus.ch_en, m_ch); m_left = eff(bus.slot_len); m_first = 1'b1;
                end
            end else begin
                m_left--; m_first = 1'b0;
                if (bus.stop) m_stopreq = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Every cycle: full output vector versus the model.
    initial forever begin
        logic [12:0] exp_v, act_v;
        logic        exp_fd;
        @(negedge clk);
        exp_fd = m_active && (m_left == 1) &&
                 (m_stopreq || bus.stop || bus.ch_en == 4'b0000 || !has_higher(bus.ch_en, m_ch));
        exp_v = {2'(m_ch), m_dout, m_dv, m_active, m_first, exp_fd};
        act_v = {bus.sel, bus.dout, bus.dout_valid, bus.busy, bus.slot_start, bus.frame_done};
        check("cycle_vector", 32'(act_v), 32'(exp_v));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] all_outs();
        return {bus.sel, bus.dout, bus.dout_valid, bus.busy, bus.slot_start, bus.frame_done};
    endfunction

    initial begin
        int t1_sel [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int t2_dout[7] = '{0, 1, 1, 1, 4, 4, 4};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.ch_en = 4'h0; bus.slot_len = 4'd0;
        bus.din = 1'b0; bus.din_valid = 1'b0;
        tick(2);
        check("reset_outputs", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // All four channels, two-cycle slots.
        bus.ch_en = 4'hF; bus.slot_len = 4'd2; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t1_sel", 32'(bus.sel), 32'(t1_sel[i-1]));
            check("t1_slot_start", 32'(bus.slot_start), 32'(i % 2));
            check("t1_frame_done", 32'(bus.frame_done), 32'(i == 8));
        end
        tick(); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        @(negedge clk);
        check("t1_stop_frame_done", 32'(bus.frame_done), 32'd1);
        tick(3);
        check("t1_idle_after_stop", 32'(bus.busy), 32'd0);

        // Channels 0 and 2, three-cycle slots, constant data.
        bus.ch_en = 4'h5; bus.slot_len = 4'd3; bus.din = 1'b1; bus.din_valid = 1'b1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check("t2_dout", 32'(bus.dout), 32'(t2_dout[i-1]));
            check("t2_dout_valid", 32'(bus.dout_valid), 32'(t2_dout[i-1]));
        end
        tick(); bus.ch_en = 4'h0; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(2);
        check("t2_idle_on_empty_mask", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        @(negedge clk);
        check("t2_start_no_channels", 32'(bus.busy), 32'd0);
        tick(); bus.ch_en = 4'h5; bus.start = 1'b1; bus.stop = 1'b1;
        tick(); bus.start = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        check("t2_start_with_stop", 32'(bus.busy), 32'd0);

        // Single channel 1, zero length treated as one cycle.
        tick(); bus.ch_en = 4'h2; bus.slot_len = 4'd0; bus.din = 1'b0; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t3_sel", 32'(bus.sel), 32'd1);
            check("t3_slot_start", 32'(bus.slot_start), 32'd1);
            check("t3_frame_done", 32'(bus.frame_done), 32'd1);
        end
        tick(); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        tick(2);

        // Stop inside a four-cycle slot: slot completes, then idle.
        bus.ch_en = 4'h3; bus.slot_len = 4'd4; bus.din = 1'b1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        @(negedge clk);
        check("t4_no_truncate_fd", 32'(bus.frame_done), 32'd0);
        check("t4_still_busy", 32'(bus.busy), 32'd1);
        tick(); @(negedge clk);
        check("t4_final_fd", 32'(bus.frame_done), 32'd1);
        tick(); @(negedge clk);
        check("t4_busy_low", 32'(bus.busy), 32'd0);
        check("t4_final_data", 32'(bus.dout), 32'd1);
        tick(); @(negedge clk);
        check("t4_dout_cleared", 32'(bus.dout), 32'd0);

        // Mask shrinks to channel 3 during the channel-0 slot.
        tick(); bus.ch_en = 4'hF; bus.slot_len = 4'd3; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(); bus.ch_en = 4'h8; bus.din = 1'b0;
        tick(); @(negedge clk);
        check("t5_ch0_end_sel", 32'(bus.sel), 32'd0);
        check("t5_ch0_end_fd", 32'(bus.frame_done), 32'd0);
        tick(); bus.din = 1'b1; @(negedge clk);
        check("t5_next_sel", 32'(bus.sel), 32'd3);
        check("t5_next_slot_start", 32'(bus.slot_start), 32'd1);
        tick(2); @(negedge clk);
        check("t5_wrap_fd", 32'(bus.frame_done), 32'd1);
        tick(); bus.ch_en = 4'h0;
        tick(4);

        // Maximum slot length on channel 2.
        bus.ch_en = 4'h4; bus.slot_len = 4'd15; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(14); @(negedge clk);
        check("t7_max_len_fd", 32'(bus.frame_done), 32'd1);
        check("t7_max_len_sel", 32'(bus.sel), 32'd2);
        tick(); @(negedge clk);
        check("t7_max_len_restart", 32'(bus.slot_start), 32'd1);
        tick(); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        tick(16);
        check("t7_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a slot.
        bus.ch_en = 4'hF; bus.slot_len = 4'd4; bus.din = 1'b1; bus.din_valid = 1'b1; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(2);
        check("t6_pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(3);
        check("t6_needs_start", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        @(negedge clk);
        check("t6_restart_busy", 32'(bus.busy), 32'd1);
        check("t6_restart_sel", 32'(bus.sel), 32'd0);
        tick(); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        tick(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
